ut_tx_arbiter: RTL
==================

// Module: ut_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter (tx_din/tx_trigger/tx_busy/tx_done) among N_REQ byte producers.
//  Round-robin arbitration, one byte per grant; holds the grant until the transmitter reports tx_done.
//  Sits between the producer blocks and the UART TX core; the RX path is untouched.
// PARAMETERS
//  N_REQ        4     number of requesters (2..8)
//  DATA_W       8     byte width, matches tx_din
//  TIMEOUT_CYC  4096  max cycles in WAIT before abort (used only with UT_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1             system clock, all logic on posedge
//  rst          in   1             synchronous reset, active-high
//  req_valid    in   N_REQ         per-requester byte available
//  req_data     in   N_REQ*DATA_W  per-requester byte, slice i = [i*DATA_W +: DATA_W]
//  req_ready    out  N_REQ         one-hot accept strobe; byte i taken when valid[i]&ready[i]
//  tx_din       out  DATA_W        byte to UART TX core
//  tx_trigger   out  1             one-cycle start pulse to UART TX core
//  tx_busy      in   1             UART TX core serialising
//  tx_done      in   1             one-cycle pulse, frame complete
//  grant_id     out  $clog2(N_REQ) index of current/last granted requester
//  timeout_err  out  1             one-cycle pulse on watchdog abort (0 when macro undefined)
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, tx_trigger=0, tx_din=0, grant_id=0, timeout_err=0, rr_ptr=N_REQ-1.
//  FSM IDLE -> TRIG -> WAIT -> IDLE.
//  IDLE: if |req_valid && !tx_busy: winner = first valid index searching rr_ptr+1, +2, ... (mod N_REQ);
//   req_ready[winner]=1 combinationally this cycle; latch req_data slice into tx_din; grant_id<=winner;
//   rr_ptr<=winner; -> TRIG. Else stay, req_ready=0.
//  TRIG: tx_trigger=1 exactly one cycle; -> WAIT.
//  WAIT: tx_din and grant_id held stable; on tx_done -> IDLE. tx_done outside WAIT ignored.
//  Latency: accept at cycle N, tx_trigger at N+1; tx_done at cycle M permits next accept at M+1.
//  At most one req_ready bit high per cycle; never high outside IDLE.
//  tx_busy high in IDLE (core used elsewhere/not settled): no grant until it drops.
//  Single requester continuously valid: granted back-to-back every frame (no starvation of itself).
//  All N valid: grants rotate 0,1,2,3,0,... starting at 0 after reset.
//  req_valid dropped while not granted: no effect; no request is latched before accept.
//  Reset asserted mid-frame: FSM returns to IDLE next edge, accepted byte discarded, rr_ptr restored.
// CONFIGURATION
//  UT_ARB_TIMEOUT_EN defined: counter cleared on entry to WAIT, increments each WAIT cycle;
//   on reaching TIMEOUT_CYC-1 without tx_done -> IDLE, timeout_err pulses 1 cycle, rr_ptr keeps winner
//   (next grant moves on). tx_done on the same cycle as expiry wins (normal completion, no error).
//  Undefined: no counter, WAIT is unbounded, timeout_err tied 0.
// STRUCTURE
//  Package ut_arb_pkg: state enum {IDLE,TRIG,WAIT} (2-bit), GRANT_W=$clog2(N_REQ) helper, DATA_W default.
//  Sub-module ut_rr_picker: combinational rotating-priority search (req vector, rr_ptr -> onehot, index, any).
//  Top holds FSM, data/grant registers, optional watchdog.
// TESTING
//  1 Reset, req_valid=4'b0001 data0=8'hA5: ready[0] at accept, tx_trigger next cycle, tx_din=A5 until tx_done.
//  2 All valid, data i=8'h10+i, tx_done 10 cycles after each trigger: grant order 0,1,2,3,0; tx_din 10,11,12,13,10.
//  3 tx_busy=1 held with req_valid=4'b0100: no ready, no trigger; release busy -> ready[2] same cycle.
//  4 Spurious tx_done pulse in IDLE and TRIG: ignored; frame still waits for tx_done in WAIT.
//  5 rst=1 during WAIT of grant 2: next cycle IDLE, outputs at reset values; next grant with all valid is 0.
//  6 UT_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, no tx_done: timeout_err pulse 16 cycles after WAIT entry, next grant
//    goes to following requester; tx_done coincident with expiry -> no timeout_err.

Source files
------------

// File: rtl/ut_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter: FSM state encoding and width helpers.
package ut_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  // Index width for n requesters; never below one bit.
  function automatic int grant_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ut_rr_picker.sv
// Combinational rotating-priority search: first set request after ptr_i, wrapping modulo N_REQ.
module ut_rr_picker
  import ut_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int GW    = grant_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [GW-1:0]    ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [GW-1:0]    idx_o,
  output logic             any_o
);

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = |req_i;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_i[(int'(ptr_i) + k) % N_REQ])
        idx_o = GW'((int'(ptr_i) + k) % N_REQ);
    end
    onehot_o[idx_o] = any_o;
  end

endmodule

// File: rtl/ut_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among N_REQ byte producers, one byte per grant.
// Optional WAIT watchdog enabled by defining UT_ARB_TIMEOUT_EN.
module ut_tx_arbiter
  import ut_arb_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_DEF,
  parameter  int DATA_W      = DATA_W_DEF,
  parameter  int TIMEOUT_CYC = TIMEOUT_DEF,
  localparam int GW          = grant_w(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]       tx_din_o,
  output logic                    tx_trigger_o,
  input  logic                    tx_busy_i,
  input  logic                    tx_done_i,
  output logic [GW-1:0]           grant_id_o,
  output logic                    timeout_err_o
);

  arb_state_e        state_q;
  logic [DATA_W-1:0] din_q;
  logic [GW-1:0]     gid_q;
  logic [GW-1:0]     rr_q;
  logic              trig_q;
  logic              err_q;

  logic [N_REQ-1:0]  pick_oh;
  logic [GW-1:0]     pick_idx;
  logic              pick_any;
  logic              accept;
  logic              expire;

  ut_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i    (req_valid_i),
    .ptr_i    (rr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign accept      = (state_q == IDLE) && pick_any && !tx_busy_i;
  assign req_ready_o = accept ? pick_oh : '0;

`ifdef UT_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC <= 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                 cnt_q <= '0;
    else if (state_q == TRIG)  cnt_q <= '0;
    else if (state_q == WAIT)  cnt_q <= cnt_q + 1'b1;
  end

  assign expire = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  // Untimed build: WAIT only ends on tx_done; the term keeps the parameter referenced.
  assign expire = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      din_q   <= '0;
      gid_q   <= '0;
      rr_q    <= GW'(N_REQ - 1);
      trig_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          din_q   <= req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
          gid_q   <= pick_idx;
          rr_q    <= pick_idx;
          trig_q  <= 1'b1;
          state_q <= TRIG;
        end
        TRIG: state_q <= WAIT;
        // Completion takes precedence over a coincident watchdog expiry.
        WAIT: if (tx_done_i) begin
          state_q <= IDLE;
        end else if (expire) begin
          state_q <= IDLE;
          err_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_din_o      = din_q;
  assign tx_trigger_o  = trig_q;
  assign grant_id_o    = gid_q;
  assign timeout_err_o = err_q;

endmodule
